// File: rtl/fb_pkg.sv
// ============================================================================
// fb_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the double-buffered framebuffer:
//   - fb_state_e   : control state of the swap/clear sequencer
//   - rgb12_t      : 4-bit red/green/blue triple (palette entry / output)
//   - FB_*_DEF     : default resolution and field widths
//   - fb_reset_pal : power-on palette contents
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int FB_H_RES_DEF   = 640;
  localparam int FB_V_RES_DEF   = 480;
  localparam int FB_COLOR_W_DEF = 4;
  localparam int FB_ROW_W_DEF   = 9;
  localparam int FB_COL_W_DEF   = 10;
  localparam int FB_PAL_DEPTH   = 16;

  typedef enum logic [1:0] {
    DRAW      = 2'd0,
    SWAP_WAIT = 2'd1,
    CLEAR     = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Power-on palette: entry i reproduces the fixed bit-replication map, so a
  // palette build looks identical to a plain build until software reloads it.
  function automatic rgb12_t fb_reset_pal(input logic [3:0] idx);
    rgb12_t e;
    e.r = idx[2] ? 4'hF : 4'h0;
    e.g = idx[1] ? 4'hF : 4'h0;
    e.b = idx[0] ? 4'hF : 4'h0;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_bank.sv
// ============================================================================
// fb_bank
// ----------------------------------------------------------------------------
// Simple dual-port RAM: one synchronous write port, one read port with a
// registered output (read-first on address collision).
// Ports:
//   clk      in   clock
//   we_i     in   write strobe
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address (sampled on clk)
//   rdata_o  out  registered read data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_bank #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fb_dbuf.sv
// ============================================================================
// fb_dbuf
// ----------------------------------------------------------------------------
// Double-buffered framebuffer. The renderer writes the back bank while
// scan-out reads the front bank by row/col. A "done" pulse arms a bank swap
// that happens on the next rising edge of vblank; the new back bank is then
// filled with CLEAR_COLOR before writes are accepted again.
//
// Optional build macro: FB_PALETTE_EN
//   defined   : 16 x 12-bit palette, low 4 pixel bits index it, adds ports
//               pal_we / pal_idx / pal_data
//   undefined : red/green/blue = pixel bit 2/1/0 replicated to 4 bits
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   w_addr      in   pixel write address (row*H_RES+col)
//   w_en        in   write strobe
//   color_in    in   pixel value to write
//   done        in   frame-complete pulse, requests a swap
//   vblank      in   vertical blank
//   row, col    in   scan-out coordinates
//   en_r        in   scan-out read enable
//   red_out     out  red intensity   (2-cycle read latency)
//   green_out   out  green intensity
//   blue_out    out  blue intensity
//   rd_valid    out  en_r delayed by two cycles
//   ready       out  back bank accepts writes
//   front_bank  out  index of the displayed bank
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_dbuf
  import fb_pkg::*;
#(
  parameter int                 H_RES       = FB_H_RES_DEF,
  parameter int                 V_RES       = FB_V_RES_DEF,
  parameter int                 COLOR_W     = FB_COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  parameter int                 ROW_W       = FB_ROW_W_DEF,
  parameter int                 COL_W       = FB_COL_W_DEF,
  parameter int                 ADDR_W      = $clog2(H_RES * V_RES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic               w_en,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               done,
  input  logic               vblank,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  input  logic               en_r,
`ifdef FB_PALETTE_EN
  input  logic               pal_we,
  input  logic [3:0]         pal_idx,
  input  logic [11:0]        pal_data,
`endif
  output logic [3:0]         red_out,
  output logic [3:0]         green_out,
  output logic [3:0]         blue_out,
  output logic               rd_valid,
  output logic               ready,
  output logic               front_bank
);

  localparam int DEPTH = H_RES * V_RES;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = ADDR_W + 1;

  // --------------------------------------------------------------------------
  // Swap / clear sequencer
  // --------------------------------------------------------------------------
  fb_state_e         state_q, state_d;
  logic              front_q, front_d;
  logic [IW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              vblank_q;
  logic              vblank_rise_w;
  logic              clr_we_w;

  assign vblank_rise_w = vblank & ~vblank_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      front_q   <= 1'b0;
      clr_cnt_q <= '0;
      vblank_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      clr_cnt_q <= clr_cnt_d;
      vblank_q  <= vblank;
    end
  end

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_w  = 1'b0;
    unique case (state_q)
      DRAW: begin
        if (done) begin
          state_d = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        // Edge-triggered on purpose: a vblank that is already high when the
        // swap is requested must fall and rise again before the swap.
        if (vblank_rise_w) begin
          front_d   = ~front_q;
          clr_cnt_d = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        clr_we_w = 1'b1;
        if (clr_cnt_q == IW'(DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = DRAW;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign ready      = (state_q == DRAW);
  assign front_bank = front_q;

  // --------------------------------------------------------------------------
  // Write path: renderer writes and clear-engine writes share one port per
  // bank; they never collide because the renderer is gated by ready.
  // --------------------------------------------------------------------------
  logic               w_in_range_w;
  logic               wr_en_w;
  logic [IW-1:0]      wr_addr_w;
  logic [COLOR_W-1:0] wr_data_w;

  assign w_in_range_w = ({1'b0, w_addr} < AW1'(DEPTH));
  assign wr_en_w      = clr_we_w | (w_en & ready & w_in_range_w);
  assign wr_addr_w    = clr_we_w ? clr_cnt_q   : w_addr[IW-1:0];
  assign wr_data_w    = clr_we_w ? CLEAR_COLOR : color_in;

  // --------------------------------------------------------------------------
  // Read path. Cycle C0: the coordinate address feeds the registered RAM
  // read port, and the in-range/enable/bank flags are captured alongside.
  // Cycle C1: RAM data is available and the colour map output is registered.
  // --------------------------------------------------------------------------
  logic [AW1-1:0]     rd_addr_w;
  logic               rd_in_range_w;
  logic               rd_ok_q;
  logic               rd_en_q;
  logic               rd_bank_q;
  logic               rd_valid_q;
  logic [COLOR_W-1:0] bank_rdata_w [2];
  logic [COLOR_W-1:0] pix_w;
  rgb12_t             rgb_w;
  rgb12_t             rgb_q;

  assign rd_addr_w     = AW1'(row) * AW1'(H_RES) + AW1'(col);
  assign rd_in_range_w = (32'(row) < 32'(V_RES)) && (32'(col) < 32'(H_RES))
                         && (rd_addr_w < AW1'(DEPTH));

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      logic bank_we_w;
      // Only the back bank (index != front) is ever written.
      assign bank_we_w = wr_en_w & (front_q != b[0]);

      fb_bank #(
        .DEPTH (DEPTH),
        .WIDTH (COLOR_W),
        .AW    (IW)
      ) u_bank (
        .clk     (clk),
        .we_i    (bank_we_w),
        .waddr_i (wr_addr_w),
        .wdata_i (wr_data_w),
        .raddr_i (rd_addr_w[IW-1:0]),
        .rdata_o (bank_rdata_w[b])
      );
    end
  endgenerate

  // The bank index is latched with the address, so a read in flight across
  // a swap still returns data from the bank that was displayed when issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ok_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rd_ok_q    <= en_r & rd_in_range_w;
      rd_en_q    <= en_r;
      rd_bank_q  <= front_q;
      rd_valid_q <= rd_en_q;
      rgb_q      <= rgb_w;
    end
  end

  assign pix_w = rd_bank_q ? bank_rdata_w[1] : bank_rdata_w[0];

  // Pixel bits beyond those the colour map consumes are intentionally spare.
  logic pix_unused_w;
  assign pix_unused_w = ^pix_w;

`ifdef FB_PALETTE_EN
  // --------------------------------------------------------------------------
  // Palette: registered table, so a same-cycle write/read of one entry
  // returns the old contents.
  // --------------------------------------------------------------------------
  rgb12_t     pal_q [FB_PAL_DEPTH];
  logic [3:0] pal_rd_idx_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FB_PAL_DEPTH; i++) begin
        pal_q[i] <= fb_reset_pal(4'(i));
      end
    end else if (pal_we) begin
      pal_q[pal_idx] <= rgb12_t'(pal_data);
    end
  end

  generate
    if (COLOR_W >= 4) begin : g_idx_wide
      assign pal_rd_idx_w = pix_w[3:0];
    end else begin : g_idx_narrow
      assign pal_rd_idx_w = {{(4 - COLOR_W){1'b0}}, pix_w};
    end
  endgenerate

  always_comb begin
    rgb_w = '0;
    if (rd_ok_q) begin
      rgb_w = pal_q[pal_rd_idx_w];
    end
  end
`else
  always_comb begin
    rgb_w = '0;
    if (rd_ok_q) begin
      rgb_w.r = {4{pix_w[2]}};
      rgb_w.g = {4{pix_w[1]}};
      rgb_w.b = {4{pix_w[0]}};
    end
  end
`endif

  assign red_out   = rgb_q.r;
  assign green_out = rgb_q.g;
  assign blue_out  = rgb_q.b;
  assign rd_valid  = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_dbuf.sv
// ============================================================================
// tb_fb_dbuf
// ----------------------------------------------------------------------------
// Directed bench for fb_dbuf at an 8x4 resolution. Inputs are driven and
// outputs sampled on the falling clock edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_dbuf;

  logic       clk;
  logic       rst;
  logic [5:0] w_addr;
  logic       w_en;
  logic [3:0] color_in;
  logic       done;
  logic       vblank;
  logic [8:0] row;
  logic [9:0] col;
  logic       en_r;
`ifdef FB_PALETTE_EN
  logic       pal_we;
  logic [3:0] pal_idx;
  logic [11:0] pal_data;
`endif
  logic [3:0] red_out;
  logic [3:0] green_out;
  logic [3:0] blue_out;
  logic       rd_valid;
  logic       ready;
  logic       front_bank;

  int vectors;
  int miscompares;

  fb_dbuf #(
    .H_RES       (8),
    .V_RES       (4),
    .COLOR_W     (4),
    .CLEAR_COLOR (4'h0),
    .ROW_W       (9),
    .COL_W       (10),
    .ADDR_W      (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_addr     (w_addr),
    .w_en       (w_en),
    .color_in   (color_in),
    .done       (done),
    .vblank     (vblank),
    .row        (row),
    .col        (col),
    .en_r       (en_r),
`ifdef FB_PALETTE_EN
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_data   (pal_data),
`endif
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .rd_valid   (rd_valid),
    .ready      (ready),
    .front_bank (front_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers (drive only, no checking) -------------
  // All helpers start and end right after a falling edge.

  task automatic write_px(input int addr, input logic [3:0] c);
    w_addr = 6'(addr); color_in = c; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
  endtask

  // early = outputs one cycle after issue, obs = outputs two cycles after.
  task automatic read_px(input int r, input int c, input logic en,
                         output logic [12:0] early, output logic [12:0] obs);
    row = 9'(r); col = 10'(c); en_r = en;
    @(negedge clk);
    en_r = 1'b0;
    early = {red_out, green_out, blue_out, rd_valid};
    @(negedge clk);
    obs = {red_out, green_out, blue_out, rd_valid};
  endtask

  // Bounded wait for ready; an expired budget counts as a failed vector.
  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready === 1'b1) break;
      @(negedge clk);
    end
    if (ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL wait_ready: ready=%b after 200 cycles, want 1", ready);
    end
  endtask

  // ---------------- scenarios ----------------------------------------------

  task automatic test_reset();
    rst = 1'b0; w_en = 0; w_addr = 0; color_in = 0; done = 0; vblank = 0;
    row = 0; col = 0; en_r = 0;
`ifdef FB_PALETTE_EN
    pal_we = 0; pal_idx = 0; pal_data = 0;
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    vectors++;
    if (front_bank !== 1'b0) begin
      miscompares++; $display("FAIL reset_front: got %b want 0", front_bank);
    end
    vectors++;
    if ({red_out, green_out, blue_out, rd_valid} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0000", {red_out, green_out, blue_out, rd_valid});
    end
    rst = 1'b1;
    // Clear of 32 words: ready rises after exactly the 32nd clock.
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      vectors++;
      if (ready !== (i == 32)) begin
        miscompares++;
        $display("FAIL reset_clear_len: cycle %0d ready=%b want %b", i, ready, (i == 32));
      end
    end
  endtask

  task automatic test_write_read();
    logic [12:0] e, o;
    write_px(9, 4'b0101);
    pulse_done();
    pulse_vblank();
    vectors++;
    if (front_bank !== 1'b1) begin
      miscompares++; $display("FAIL swap1_front: got %b want 1", front_bank);
    end
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL swap1_ready: got %b want 0", ready);
    end
    wait_ready();
    read_px(1, 1, 1'b1, e, o);
    vectors++;
    if (e !== 13'h0) begin
      miscompares++; $display("FAIL rd_latency_early: got %h want 0000", e);
    end
    vectors++;
    if (o !== {4'hF, 4'h0, 4'hF, 1'b1}) begin
      miscompares++; $display("FAIL rd_pix9: got %h want %h", o, {4'hF, 4'h0, 4'hF, 1'b1});
    end
    read_px(0, 0, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL rd_cleared_px: got %h want 0001", o);
    end
    read_px(1, 1, 1'b0, e, o);
    vectors++;
    if (o !== 13'h0000) begin
      miscompares++; $display("FAIL rd_en_low: got %h want 0000", o);
    end
  endtask

  task automatic test_out_of_range();
    logic [12:0] e, o;
    read_px(4, 0, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL oor_row: got %h want 0001", o);
    end
    read_px(0, 8, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL oor_col: got %h want 0001", o);
    end
    write_px(32, 4'h7);          // out of range: must not alias onto pixel 0
    write_px(31, 4'h6);          // last valid address
    // Write in the same cycle as done is still accepted.
    w_addr = 6'd2; color_in = 4'h1; w_en = 1'b1; done = 1'b1;
    @(negedge clk);
    w_en = 1'b0; done = 1'b0;
    pulse_vblank();
    vectors++;
    if (front_bank !== 1'b0) begin
      miscompares++; $display("FAIL swap2_front: got %b want 0", front_bank);
    end
    wait_ready();
    read_px(0, 0, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL oor_write_dropped: got %h want 0001", o);
    end
    read_px(3, 7, 1'b1, e, o);
    vectors++;
    if (o !== {4'hF, 4'hF, 4'h0, 1'b1}) begin
      miscompares++; $display("FAIL last_addr: got %h want %h", o, {4'hF, 4'hF, 4'h0, 1'b1});
    end
    read_px(0, 2, 1'b1, e, o);
    vectors++;
    if (o !== {4'h0, 4'h0, 4'hF, 1'b1}) begin
      miscompares++; $display("FAIL write_with_done: got %h want %h", o, {4'h0, 4'h0, 4'hF, 1'b1});
    end
  endtask

  task automatic test_write_blocked();
    logic [12:0] e, o;
    pulse_done();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL swait_ready: got %b want 0", ready);
    end
    write_px(3, 4'h7);           // dropped: SWAP_WAIT
    pulse_vblank();
    vectors++;
    if (front_bank !== 1'b1) begin
      miscompares++; $display("FAIL swap3_front: got %b want 1", front_bank);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL clear_ready: got %b want 0", ready);
    end
    write_px(4, 4'h7);           // dropped: CLEAR, counter already past 4
    wait_ready();
    read_px(0, 3, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL swait_write_dropped: got %h want 0001", o);
    end
    pulse_done();
    pulse_vblank();
    vectors++;
    if (front_bank !== 1'b0) begin
      miscompares++; $display("FAIL swap4_front: got %b want 0", front_bank);
    end
    wait_ready();
    read_px(0, 4, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL clear_write_dropped: got %h want 0001", o);
    end
    read_px(3, 7, 1'b1, e, o);
    vectors++;
    if (o !== 13'h0001) begin
      miscompares++; $display("FAIL bank_cleared: got %h want 0001", o);
    end
  endtask

  task automatic test_vblank_high();
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done();
    repeat (3) @(negedge clk);
    vectors++;
    if (front_bank !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL vb_high_hold: front=%b ready=%b want front=0 ready=0", front_bank, ready);
    end
    vblank = 1'b0;
    @(negedge clk);
    vectors++;
    if (front_bank !== 1'b0) begin
      miscompares++; $display("FAIL vb_fall: got %b want 0", front_bank);
    end
    vblank = 1'b1;
    @(negedge clk);
    vectors++;
    if (front_bank !== 1'b1) begin
      miscompares++; $display("FAIL vb_rise: got %b want 1", front_bank);
    end
    vblank = 1'b0;
    wait_ready();
  endtask

  task automatic test_palette();
    logic [12:0] e, o;
    write_px(9, 4'h5);
    pulse_done();
    pulse_vblank();
    wait_ready();
    read_px(1, 1, 1'b1, e, o);
    vectors++;
    if (o !== {4'hF, 4'h0, 4'hF, 1'b1}) begin
      miscompares++; $display("FAIL pix5_default: got %h want %h", o, {4'hF, 4'h0, 4'hF, 1'b1});
    end
`ifdef FB_PALETTE_EN
    pal_idx = 4'd5; pal_data = 12'h123; pal_we = 1'b1;
    @(negedge clk);
    pal_we = 1'b0;
    read_px(1, 1, 1'b1, e, o);
    vectors++;
    if (o !== {4'h1, 4'h2, 4'h3, 1'b1}) begin
      miscompares++; $display("FAIL pix5_palette: got %h want %h", o, {4'h1, 4'h2, 4'h3, 1'b1});
    end
`endif
  endtask

  task automatic test_reset_mid();
    pulse_done();
    pulse_vblank();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (front_bank !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: front=%b ready=%b want front=0 ready=0", front_bank, ready);
    end
    rst = 1'b1;
    repeat (31) @(negedge clk);
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL midreset_clear31: got %b want 0", ready);
    end
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++; $display("FAIL midreset_clear32: got %b want 1", ready);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_write_blocked();
    test_vblank_high();
    test_palette();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_dbuf.md
Name: fb_dbuf

Overview:
- Parametrised double-buffered framebuffer for the vector renderer.
- The renderer draws into a back bank while VGA scan-out reads the front bank by row/col.
- When the renderer signals `done`, the banks swap at the next vertical-blank edge.
- After the swap, a built-in clear engine fills the new back bank with a clear colour before drawing is re-enabled.

Parameters:
- H_RES, 640, visible pixels per row.
- V_RES, 480, visible rows.
- COLOR_W, 4, bits per stored pixel (minimum 3).
- CLEAR_COLOR, 0, value the clear engine writes, COLOR_W bits.
- ROW_W, 9, width of row input.
- COL_W, 10, width of col input.
- ADDR_W, $clog2(H_RES*V_RES), write/read address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- w_addr  in  ADDR_W  pixel write address, row*H_RES+col.
- w_en  in  1  write strobe.
- color_in  in  COLOR_W  pixel value to write.
- done  in  1  frame-complete pulse from the renderer; requests a swap.
- vblank  in  1  vertical blank from the VGA timing block.
- row  in  ROW_W  scan-out row.
- col  in  COL_W  scan-out column.
- en_r  in  1  scan-out read enable.
- red_out  out  4  red intensity.
- green_out  out  4  green intensity.
- blue_out  out  4  blue intensity.
- rd_valid  out  1  red/green/blue are valid for the read issued 2 cycles earlier.
- ready  out  1  back bank accepts writes.
- front_bank  out  1  index of the bank being displayed.

Behaviour:
- Two banks, each H_RES*V_RES words of COLOR_W bits, in inferred RAM.
- Reset values: front_bank=0, ready=0, rd_valid=0, all colour outputs 0, state=CLEAR, clear counter=0. Reset is effective mid-operation: an in-progress clear or a pending swap is abandoned.
- Read pipeline, latency 2:
  - C0: row/col are sampled and addr=row*H_RES+col is registered; the in-range flag is row<V_RES && col<H_RES.
  - C1: front-bank RAM is read.
  - C2: colour outputs are registered; rd_valid = en_r delayed by 2.
  - en_r=0, or out-of-range row/col: colour outputs are 0 in C2.
  - Colour map: red = color[2] replicated to 4 bits, green = color[1] replicated, blue = color[0] replicated.
  - Reads in flight at a swap complete from the bank latched at C0.
- Writes:
  - Accepted only when w_en && ready && w_addr<H_RES*V_RES; written to bank !front_bank in the same cycle.
  - Writes with w_addr out of range, or issued while ready=0, are dropped silently.
- State machine:
  - DRAW: ready=1. done=1 → SWAP_WAIT. A w_en write in the same cycle as done is still accepted.
  - SWAP_WAIT: ready=0. On a vblank rising edge (vblank registered, edge = vblank & ~vblank_q) toggle front_bank → CLEAR. done is ignored. If vblank is already high on entry, the swap waits for the next rising edge.
  - CLEAR: ready=0. Write CLEAR_COLOR to bank !front_bank, one word per cycle at addresses 0..H_RES*V_RES-1. The clear counter wraps to 0 after the last address → DRAW. done is ignored.
- Clear duration is exactly H_RES*V_RES cycles (307200 at default).
- Reset clears bank 1 only; bank 0 contents are undefined until after the first swap and clear.
- Address arithmetic uses ADDR_W+1 bits internally; the row*H_RES product is not truncated before the range check.

Optional Feature:
- FB_PALETTE_EN defined:
  - Adds ports pal_we (in, 1), pal_idx (in, 4), pal_data (in, 12, {R,G,B}).
  - Adds a 16-entry x 12-bit palette; reset loads entry i = {i[2]?F:0, i[1]?F:0, i[0]?F:0}.
  - In C2 the low 4 bits of the pixel index the palette and red/green/blue come from the entry.
  - pal_we updates the entry at the next edge; a read of the same entry in the same cycle returns the old value.
- Undefined: fixed bit-replication map as above; no palette ports.

Decomposition:
- Package fb_pkg holds:
  - fb_state_e typedef (DRAW, SWAP_WAIT, CLEAR).
  - rgb12_t struct (three 4-bit fields).
  - Default resolution constants.
  - The reset palette function.
- One sub-module fb_bank: simple dual-port RAM, 1 write port and 1 registered read port, parametrised by depth and width, instantiated twice.

Test Plan:
- Use H_RES=8, V_RES=4 for all scenarios.
- Reset release: ready=0 for 32 cycles, then 1; front_bank=0; reading any pixel gives 0 after the first swap.
- Write color_in=4'b0101 at w_addr=9, pulse done, raise vblank → front_bank=1. Read row=1,col=1 with en_r=1 → red=0, green=F, blue=F is wrong; the required result is red=F, green=0, blue=F, rd_valid=1 exactly 2 cycles later.
- Read row=4,col=0 (out of range) → outputs 0, rd_valid=1; a write at w_addr=32 is dropped.
- Write during SWAP_WAIT/CLEAR (w_en=1, ready=0) → the target pixel still reads CLEAR_COLOR after the next swap.
- done asserted while vblank already high → no swap until vblank falls and rises again; front_bank toggles on that edge only.
- With FB_PALETTE_EN: pal_we, idx=5, data=12'h123; pixel value 5 → red=1, green=2, blue=3. Without the macro, the same pixel → F,0,F.
